aes_key_unexpansion_128: RTL and testbench

- Reverse AES-128 key schedule for the decryption datapath.
- Takes the round-10 key and emits round keys 10, 9, …, 0, one per accepted handshake.
- Inverse cipher rounds can consume keys in order without storing all 11.
- Sits between the key loader and the inverse-round pipeline; mirror of the forward key expander.

---
 rtl/aes_key_unexpansion_128.sv | 236 +++++++++++++++++++++++
 tb/tb_aes_key_unexpansion_128.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_unexpansion_128.sv
// aes_key_unexpansion_128
// Reverse AES-128 key schedule. Accepts the round-10 key and hands out round
// keys 10, 9, ..., 0 over a valid/ready interface so the inverse cipher can
// consume them in order without storing the whole schedule.
//
// Optional build macro: AES_KEY_UNEXP_FWD_EN
//   When defined, last_key is the cipher (round-0) key. An EXPAND state runs
//   the forward schedule for ten cycles to reach the round-10 key before the
//   reverse emission starts. The SubWord S-boxes are shared between the
//   forward and reverse steps.
module aes_key_unexpansion_128 #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         key_ready,
    output logic [127:0] subkey,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_lookup(w[31:24]), sbox_lookup(w[23:16]),
                sbox_lookup(w[15:8]),  sbox_lookup(w[7:0])};
    endfunction

    // Round constant for round r (1..10); r=0 never reaches the XOR.
    function automatic logic [7:0] rcon_byte(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   subkey_q, subkey_d;
    logic [3:0]     round_idx_q, round_idx_d;
    logic           key_valid_q, key_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // A start coinciding with the done pulse belongs to the finished run.
    logic           start_ok;
    assign start_ok = start && !done_q;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    p0, p1, p2, p3;
    logic [31:0]    sub_in, sub_out, rcon_w;
    logic [127:0]   prev_key;
`ifdef AES_KEY_UNEXP_FWD_EN
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   fwd_key;
`endif

    // Single-cycle key step from the subkey register; one shared SubWord.
    always_comb begin
        w0       = subkey_q[127:96];
        w1       = subkey_q[95:64];
        w2       = subkey_q[63:32];
        w3       = subkey_q[31:0];
        rcon_w   = {rcon_byte(round_idx_q), 24'h000000};
        p3       = w3 ^ w2;
        p2       = w2 ^ w1;
        p1       = w1 ^ w0;
`ifdef AES_KEY_UNEXP_FWD_EN
        sub_in   = (state_q == EXPAND) ? w3 : p3;
`else
        sub_in   = p3;
`endif
        sub_out  = sub_word(rot_word(sub_in));
        p0       = w0 ^ sub_out ^ rcon_w;
        prev_key = {p0, p1, p2, p3};
`ifdef AES_KEY_UNEXP_FWD_EN
        n0       = w0 ^ sub_out ^ rcon_w;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        fwd_key  = {n0, n1, n2, n3};
`endif
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            subkey_q    <= '0;
            round_idx_q <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            subkey_q    <= subkey_d;
            round_idx_q <= round_idx_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
`ifdef AES_KEY_UNEXP_FWD_EN
                    state_d = EXPAND;
`else
                    state_d = EMIT;
`endif
                end
            end
`ifdef AES_KEY_UNEXP_FWD_EN
            EXPAND: begin
                if (round_idx_q == LAST_ROUND) begin
                    state_d = EMIT;
                end
            end
`endif
            EMIT: begin
                if (key_ready && (round_idx_q == 4'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register next values: key load, forward expansion, reverse emission.
    always_comb begin
        subkey_d    = subkey_q;
        round_idx_d = round_idx_q;
        key_valid_d = key_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    subkey_d = last_key;
                    busy_d   = 1'b1;
`ifdef AES_KEY_UNEXP_FWD_EN
                    // round_idx counts the target round of the next forward step.
                    round_idx_d = 4'd1;
                    key_valid_d = 1'b0;
`else
                    round_idx_d = LAST_ROUND;
                    key_valid_d = 1'b1;
`endif
                end
            end
`ifdef AES_KEY_UNEXP_FWD_EN
            EXPAND: begin
                subkey_d = fwd_key;
                if (round_idx_q == LAST_ROUND) begin
                    key_valid_d = 1'b1;
                end else begin
                    round_idx_d = round_idx_q + 4'd1;
                end
            end
`endif
            EMIT: begin
                if (key_ready) begin
                    if (round_idx_q != 4'd0) begin
                        subkey_d    = prev_key;
                        round_idx_d = round_idx_q - 4'd1;
                    end else begin
                        key_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            default: begin
                key_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign subkey    = subkey_q;
    assign round_idx = round_idx_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_unexpansion_128.sv
// Scoreboard bench for aes_key_unexpansion_128. Builds with or without
// AES_KEY_UNEXP_FWD_EN; in the forward build the round-0 key is driven.
module tb_aes_key_unexpansion_128;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] last_key = '0;
    logic         key_ready = 1'b1;
    logic [127:0] subkey;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    aes_key_unexpansion_128 #(.NR(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .last_key  (last_key),
        .key_ready (key_ready),
        .subkey    (subkey),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

`ifdef AES_KEY_UNEXP_FWD_EN
    localparam int  LAT = 11;
    localparam bit  FWD = 1'b1;
`else
    localparam int  LAT = 1;
    localparam bit  FWD = 1'b0;
`endif

    // FIPS-197 Appendix A.1 round keys 0..10.
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   idx;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] exp_keys [0:10];
    int           checks = 0;
    int           failures = 0;
    bit           done_due = 1'b0;

    task automatic do_check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference S-box from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15 - n -: 8];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subrot_ref(input logic [31:0] w);
        return {sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0]), sbox_ref(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon_ref(input int r);
        logic [7:0] rc = 8'h01;
        for (int i = 1; i < r; i++) rc = xtime(rc);
        return rc;
    endfunction

    // Word-array recurrence run backwards from the round-10 key.
    task automatic build_model(input logic [127:0] k10);
        logic [31:0] w [0:43];
        logic [31:0] t;
        w[40] = k10[127:96];
        w[41] = k10[95:64];
        w[42] = k10[63:32];
        w[43] = k10[31:0];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = subrot_ref(t) ^ {rcon_ref(i / 4), 24'h000000};
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_fips();
        for (int r = 0; r <= 10; r++) exp_keys[r] = FIPS_RK[r];
    endtask

    // Queue the expected keys, pulse start for one cycle, measure latency.
    task automatic issue_seq();
        int lat = 0;
        bit got = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        for (int r = 10; r >= 0; r--) begin
            e.key = exp_keys[r];
            e.idx = 4'(r);
            sb_q.push_back(e);
        end
        last_key = FWD ? exp_keys[0] : exp_keys[10];
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (key_valid) got = 1'b1;
        end
        do_check("first_valid_latency", 128'(lat), 128'(LAT));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        do_check("done_seen", 128'(done), 128'(1));
        do_check("sb_drained", 128'(sb_q.size()), 128'(0));
        do_check("key_valid_after_done", 128'(key_valid), 128'(0));
    endtask

    // Monitor: compares the presented key against the queue head every cycle
    // it is valid and pops on handshake, so stalls are checked for stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sb_q.delete();
                done_due = 1'b0;
            end else begin
                if (done_due) begin
                    do_check("done_pulse", 128'(done), 128'(1));
                    do_check("busy_at_done", 128'(busy), 128'(0));
                    done_due = 1'b0;
                end else if (done) begin
                    do_check("done_spurious", 128'(done), 128'(0));
                end
                if (key_valid) begin
                    if (sb_q.size() == 0) begin
                        do_check("unexpected_key_valid", 128'(key_valid), 128'(0));
                    end else begin
                        e = sb_q[0];
                        do_check($sformatf("subkey_r%0d", e.idx), subkey, e.key);
                        do_check($sformatf("round_idx_r%0d", e.idx), 128'(round_idx), 128'(e.idx));
                        do_check("busy_while_valid", 128'(busy), 128'(1));
                        if (key_ready) begin
                            void'(sb_q.pop_front());
                            if (e.idx == 4'd0) done_due = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        #1 reset = 1'b0;
        #2;
        do_check("rst_subkey", subkey, 128'(0));
        do_check("rst_round_idx", 128'(round_idx), 128'(0));
        do_check("rst_key_valid", 128'(key_valid), 128'(0));
        do_check("rst_busy", 128'(busy), 128'(0));
        do_check("rst_done", 128'(done), 128'(0));
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;

        // Full FIPS-197 sequence, consumer always ready.
        load_fips();
        issue_seq();
        wait_done();

        // Stall five cycles while round 9 is presented.
        load_fips();
        issue_seq();
        @(posedge clk); #1 key_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 key_ready = 1'b1;
        wait_done();

        // start during EMIT with another key is ignored.
        load_fips();
        issue_seq();
        repeat (3) @(posedge clk);
        #1;
        last_key = 128'h00112233445566778899aabbccddeeff;
        start    = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        // start held across the done pulse cycle only is also ignored.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(negedge clk);
        do_check("busy_after_done_start", 128'(busy), 128'(0));

        // Asynchronous abort while round 5 is presented.
        load_fips();
        issue_seq();
        repeat (5) @(posedge clk);
        #1;
        do_check("round_before_abort", 128'(round_idx), 128'(5));
        reset = 1'b0;
        #1;
        do_check("abort_subkey", subkey, 128'(0));
        do_check("abort_round_idx", 128'(round_idx), 128'(0));
        do_check("abort_key_valid", 128'(key_valid), 128'(0));
        do_check("abort_busy", 128'(busy), 128'(0));
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        load_fips();
        issue_seq();
        wait_done();

        // All-zero round-10 key against the reference model.
        build_model(128'h0);
        issue_seq();
        wait_done();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
